// File: rtl/mul_div_unit_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mul_div_unit_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    // LO value produced by a divide whose divisor is zero.
    localparam logic [MDU_WIDTH-1:0] DIV0_LO = '1;

endpackage

// File: rtl/mul_div_unit_if.sv
// EX-stage <-> multiply/divide unit bundle: launch, MTHI/MTLO writes and HI/LO results.
interface mul_div_unit_if
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
);
    logic             start;
    op_t              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit_sign_fix.sv
// Combinational two's-complement conditional negate (abs at capture, sign restore at FIX).
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] val,
    output logic [W-1:0] res
);
    logic signed [W-1:0] val_s;

    assign val_s = val;
    assign res   = neg ? -val_s : val_s;
endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO; one bit per cycle, sign handled outside the loop.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  bus
);
    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               is_signed;
    logic               sign_a;
    logic               sign_b;
    logic               div0;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               done;

    logic               start_signed;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;

    assign start_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);

    mdu_sign_fix #(.W(WIDTH)) u_abs_a (
        .neg (start_signed & bus.a[WIDTH-1]),
        .val (bus.a),
        .res (a_abs)
    );

    mdu_sign_fix #(.W(WIDTH)) u_abs_b (
        .neg (start_signed & bus.b[WIDTH-1]),
        .val (bus.b),
        .res (b_abs)
    );

    mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (
        .neg (is_signed & (sign_a ^ sign_b)),
        .val (acc),
        .res (prod_fix)
    );

    mdu_sign_fix #(.W(WIDTH)) u_fix_quo (
        .neg (is_signed & (sign_a ^ sign_b)),
        .val (quo),
        .res (quo_fix)
    );

    mdu_sign_fix #(.W(WIDTH)) u_fix_rem (
        .neg (is_signed & sign_a),
        .val (rem[WIDTH-1:0]),
        .res (rem_fix)
    );

    // Multiply: low half of acc holds the remaining multiplier bits, shifted out LSB first.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

    // Divide: restoring step, dividend bits enter the remainder from the top of quo.
    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_ge    = (div_shift >= {2'b00, opnd});
    assign div_diff  = div_shift[WIDTH:0] - {1'b0, opnd};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            div0      <= 1'b0;
            acc       <= '0;
            rem       <= '0;
            quo       <= '0;
            opnd      <= '0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.hi_we) hi <= bus.wdata;
                    if (bus.lo_we) lo <= bus.wdata;
                    if (bus.start) begin
                        is_div    <= bus.op[1];
                        is_signed <= start_signed;
                        sign_a    <= start_signed & bus.a[WIDTH-1];
                        sign_b    <= start_signed & bus.b[WIDTH-1];
                        div0      <= (bus.b == '0);
                        cnt       <= '0;
                        rem       <= '0;
                        if (bus.op[1]) begin
                            opnd <= b_abs;
                            quo  <= a_abs;
                            acc  <= '0;
                        end else begin
                            opnd <= a_abs;
                            quo  <= '0;
                            acc  <= {{WIDTH{1'b0}}, b_abs};
                        end
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (is_div) begin
                        rem <= div_ge ? div_diff : div_shift[WIDTH:0];
                        quo <= {quo[WIDTH-2:0], div_ge};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH-1)) state <= ST_FIX;
                end
                ST_FIX: begin
                    if (is_div) begin
                        lo <= div0 ? DIV0_LO : quo_fix;
                        hi <= rem_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = (state != ST_IDLE);
    assign bus.done = done;
    assign bus.hi   = hi;
    assign bus.lo   = lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic results, latency, busy/done timing, MT writes and reset abort.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input op_t o, input logic [31:0] av, input logic [31:0] bv);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = av;
        bus.b     = bv;
        step();
        bus.start = 1'b0;
        bus.op    = OP_DIVU;
        bus.a     = ~av;
        bus.b     = ~bv;
    endtask

    // Checks busy=1/done=0 for n cycles, then the done cycle and the written HI/LO.
    task automatic finish_op(input string tag, input int n, input logic [31:0] hi_e, input logic [31:0] lo_e);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
            step();
        end
        check({tag, "_busy_window"}, 32'(bad), 32'd0);
        check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
        check({tag, "_busy_off"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_hi"}, bus.hi, hi_e);
        check({tag, "_lo"}, bus.lo, lo_e);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;

        step(); step(); step();
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        reset = 1'b1;
        step();

        launch(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        finish_op("mult_neg", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        step();
        check("mult_done_pulse", {31'd0, bus.done}, 32'd0);

        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("multu_max", 33, 32'hFFFF_FFFE, 32'h0000_0001);

        launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        finish_op("div_neg", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        launch(OP_DIVU, 32'd100, 32'd0);
        finish_op("divu_zero", 33, 32'd100, 32'hFFFF_FFFF);

        launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_ovf", 33, 32'd0, 32'h8000_0000);
        step();

        // Start and MTHI issued mid-operation must both be ignored.
        launch(OP_MULTU, 32'h1234_5678, 32'h0000_0100);
        for (int i = 0; i < 9; i++) step();
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a     = 32'd5;
        bus.b     = 32'd1;
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_1234;
        step();
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        check("mid_hi_ignored", bus.hi, 32'd0);
        finish_op("mid_multu", 23, 32'h0000_0012, 32'h3456_7800);
        step();
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_ABCD;
        step();
        bus.lo_we = 1'b0;
        check("mtlo_lo", bus.lo, 32'h0000_ABCD);
        check("mtlo_hi_kept", bus.hi, 32'h0000_0012);

        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_5555;
        step();
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        check("preload_hi", bus.hi, 32'h0000_5555);
        check("preload_lo", bus.lo, 32'h0000_5555);

        launch(OP_DIV, 32'd1000, 32'd3);
        for (int i = 0; i < 19; i++) step();
        check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        step();
        reset = 1'b1;
        step();
        check("abort_idle", {31'd0, bus.busy}, 32'd0);

        launch(OP_DIVU, 32'd9, 32'd4);
        finish_op("divu_small", 33, 32'd1, 32'd2);

        launch(OP_MULTU, 32'd7, 32'd6);
        finish_op("b2b_multu", 33, 32'd0, 32'd42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multi-cycle multiply/divide unit for the pipelined MIPS datapath.
- Executes MULT, MULTU, DIV and DIVU, none of which the single-cycle ALU handles.
- Owns the architectural HI/LO registers and supports MTHI/MTLO writes.
- The EX stage launches an operation with a start pulse. The hazard unit stalls MFHI/MFLO and further MDU ops while busy is high.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH each; only 32 is verified
CNT_W, 6, iteration counter width; must hold WIDTH

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  launch operation; sampled only when busy=0
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  input  WIDTH  rs operand (multiplicand / dividend)
b  input  WIDTH  rt operand (multiplier / divisor)
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wdata  input  WIDTH  MTHI/MTLO data
busy  output  1  operation in progress
done  output  1  one-cycle pulse when HI/LO receive a result
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; hi=0, lo=0, busy=0, done=0; counter and working registers=0.
  - Reset asserted mid-operation aborts it. No done pulse is produced.
- States: IDLE, RUN, FIX. busy = (state != IDLE), decoded from registered state.
- IDLE with start=1 at edge E0:
  - Latch op and sign flags (a[31], b[31], signed only).
  - Latch |a| and |b| for signed ops; raw a and b for unsigned ops.
  - counter=0; go to RUN.
- RUN, one iteration per edge, E1..E32 (32 edges):
  - Multiply: radix-2 shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; remainder WIDTH+1 bits, quotient WIDTH bits.
  - At counter=WIDTH-1 the edge goes to FIX.
- FIX at E33:
  - Apply sign correction.
    - Signed multiply: negate the 64-bit product if sign_a^sign_b.
    - Signed divide: negate the quotient if sign_a^sign_b; the remainder takes sign_a.
  - Write hi/lo. Go to IDLE. done registers to 1 for exactly the cycle following E33.
  - Mult: {hi,lo} = product. Div: lo = quotient, hi = remainder.
- Latency:
  - start cycle -> done cycle = 34 cycles.
  - busy is high in the 33 cycles after E0.
  - A new start is accepted in the done cycle (back-to-back).
- start while busy: ignored, with no effect on the in-flight operation.
- op, a and b are don't-care after E0.
- Divide by zero, DIV or DIVU: same latency; lo = 32'hFFFFFFFF, hi = a (original, unsigned view).
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo = 32'h80000000, hi = 0.
- MTHI/MTLO:
  - In IDLE, hi_we/lo_we write wdata into hi/lo at the next edge.
  - While busy, both are ignored.
  - If start and hi_we/lo_we arrive in the same IDLE cycle, the write takes effect now and the result later overwrites it.
- hi/lo hold their values at all times except the FIX edge, MT writes and reset. They are never partially updated during RUN.

Decomposition:
- Shared package:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - state encoding: ST_IDLE, ST_RUN, ST_FIX.
  - WIDTH default.
  - DIV0_LO constant.
- One sub-module is natural: mdu_sign_fix.
  - Purely combinational two's-complement negate/abs helper.
  - Used at operand capture and in FIX.
- Control FSM and datapath stay in mul_div_unit.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3 -> after 34 cycles done=1; hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high for the 33 cycles before done.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100. Second case, DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Mid-op: at cycle 10 of MULTU pulse start with different operands and hi_we=1 (wdata=0x1234) -> both ignored; the original result lands. Afterwards in IDLE, lo_we=1 with wdata=0xABCD -> lo=0xABCD next cycle.
- Reset: drop reset low at cycle 20 of DIV with hi=lo=0x5555 preloaded -> busy=0, done=0, hi=lo=0 immediately (async). After release, start DIVU 9/4 -> lo=2, hi=1 after 34 cycles. Also start a new op in the done cycle -> accepted, next done 34 cycles later.
